// File: rtl/qsfp_scan_sequencer.sv
// -----------------------------------------------------------------------------
// qsfp_scan_sequencer
//
// Purpose:
//    Power-up and periodic scan sequencer for a group of QSFP sideband
//    channels. After a reset hold-off it starts the power engine, then runs an
//    INIT pass and repeated SCAN passes over the enabled channels. Between
//    passes it idles for SCAN_PERIOD cycles. It also arbitrates one shared I2C
//    controller between the engine slots: slot 0 is power and slot k+1 is
//    channel k. Only the slot being waited on is granted the bus.
//
// Optional feature:
//    `define QSFP_SCAN_SEQ_TIMEOUT_EN enables a per-WAIT watchdog. When it
//    expires it sets a sticky timeout_err bit for that slot and advances as
//    if the operation had completed. Without the macro, WAIT states wait
//    indefinitely and timeout_err is tied to 0.
//
// Ports:
//    clk, rst                      single clock, synchronous active-high reset
//    ch_enable[N_CH]               per-channel participation mask
//    pwr_start / pwr_cmplt         power engine start pulse / completion
//    ch_start, ch_init / ch_cmplt  per-channel start pulse, init qualifier /
//                                  completion
//    eng_pulse, eng_rw, eng_id,    engine-side request buses, one lane per slot
//    eng_addr, eng_wdata
//    eng_rdata, eng_cmplt          read data and completion back to engines
//    IO_*                          shared I2C controller interface
//    timeout_err[N_CH+1]           sticky watchdog flags per slot
//    busy, dbg_state               status
// -----------------------------------------------------------------------------
module qsfp_scan_sequencer #(
   parameter int N_CH        = 4,
   parameter int RST_DLY     = 50000000,
   parameter int SCAN_PERIOD = 50000000,
   parameter int TIMEOUT     = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       ch_enable,
   output logic                  pwr_start,
   input  logic                  pwr_cmplt,
   output logic [N_CH-1:0]       ch_start,
   output logic [N_CH-1:0]       ch_init,
   input  logic [N_CH-1:0]       ch_cmplt,
   input  logic [N_CH:0]         eng_pulse,
   input  logic [N_CH:0]         eng_rw,
   input  logic [8*(N_CH+1)-1:0] eng_id,
   input  logic [8*(N_CH+1)-1:0] eng_addr,
   input  logic [8*(N_CH+1)-1:0] eng_wdata,
   output logic                  IO_CONTROL_PULSE,
   output logic                  IO_CONTROL_RW,
   output logic [7:0]            IO_CONTROL_ID,
   output logic [7:0]            IO_ADDR_ADDR,
   output logic [7:0]            IO_WDATA_WDATA,
   input  logic [7:0]            IO_RDATA_RDATA,
   input  logic                  IO_CONTROL_CMPLT,
   output logic [7:0]            eng_rdata,
   output logic [N_CH:0]         eng_cmplt,
   output logic [N_CH:0]         timeout_err,
   output logic                  busy,
   output logic [7:0]            dbg_state
);

   localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int SLOT_W = $clog2(N_CH + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

   // Parameter range guard, evaluated at elaboration only
   if (N_CH < 1 || N_CH > 8 || RST_DLY < 1 || SCAN_PERIOD < 0 || TIMEOUT < 1) begin : g_param_check
      $error("qsfp_scan_sequencer: parameter out of range");
   end

   typedef enum logic [2:0] {
      ST_RST        = 3'd0,
      ST_PWR_ISSUE  = 3'd1,
      ST_PWR_WAIT   = 3'd2,
      ST_INIT_ISSUE = 3'd3,
      ST_INIT_WAIT  = 3'd4,
      ST_SCAN_ISSUE = 3'd5,
      ST_SCAN_WAIT  = 3'd6,
      ST_DELAY      = 3'd7
   } state_t;

   state_t            state_r, next_state_s;
   logic [IDX_W-1:0]  idx_r, next_idx_s;
   // Shared down-counter: reset hold-off, inter-pass delay and watchdog never
   // overlap in time, so one counter serves all three.
   logic [31:0]       cnt_r, next_cnt_s;
   logic              slot_done_s;
   logic              init_phase_s;
   logic              granted_s;
   logic [SLOT_W-1:0] slot_s;
   logic              wd_expire_s;

   assign granted_s    = (state_r inside {ST_PWR_WAIT, ST_INIT_WAIT, ST_SCAN_WAIT});
   assign slot_s       = (state_r == ST_PWR_WAIT) ? SLOT_W'(0) : (SLOT_W'(idx_r) + SLOT_W'(1));
   assign init_phase_s = (state_r inside {ST_INIT_ISSUE, ST_INIT_WAIT});

`ifdef QSFP_SCAN_SEQ_TIMEOUT_EN
   logic [N_CH:0] timeout_err_r;

   assign wd_expire_s = granted_s && (cnt_r <= 32'd1);
   assign timeout_err = timeout_err_r;

   // Sticky per-slot watchdog flags, cleared only by rst
   always_ff @(posedge clk) begin
      if (rst) begin
         timeout_err_r <= '0;
      end else if (wd_expire_s) begin
         timeout_err_r[slot_s] <= 1'b1;
      end else begin
         timeout_err_r <= timeout_err_r;
      end
   end
`else
   assign wd_expire_s = 1'b0;
   assign timeout_err = '0;
`endif

   // State, channel index and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_RST;
         idx_r   <= '0;
         cnt_r   <= 32'(RST_DLY);
      end else begin
         state_r <= next_state_s;
         idx_r   <= next_idx_s;
         cnt_r   <= next_cnt_s;
      end
   end

   // Next-state, index and counter logic
   always_comb begin
      next_state_s = state_r;
      next_idx_s   = idx_r;
      next_cnt_s   = cnt_r;
      slot_done_s  = 1'b0;
      case (state_r)
         ST_RST: begin
            if (cnt_r == 32'd0) begin
               next_state_s = ST_PWR_ISSUE;
            end else begin
               next_cnt_s = cnt_r - 32'd1;
            end
         end
         ST_PWR_ISSUE: begin
            next_state_s = ST_PWR_WAIT;
`ifdef QSFP_SCAN_SEQ_TIMEOUT_EN
            next_cnt_s = 32'(TIMEOUT);
`endif
         end
         ST_PWR_WAIT: begin
            if (pwr_cmplt || wd_expire_s) begin
               next_state_s = ST_INIT_ISSUE;
               next_idx_s   = '0;
            end else begin
`ifdef QSFP_SCAN_SEQ_TIMEOUT_EN
               next_cnt_s = cnt_r - 32'd1;
`endif
            end
         end
         ST_INIT_ISSUE, ST_SCAN_ISSUE: begin
            if (ch_enable[idx_r]) begin
               next_state_s = init_phase_s ? ST_INIT_WAIT : ST_SCAN_WAIT;
`ifdef QSFP_SCAN_SEQ_TIMEOUT_EN
               next_cnt_s = 32'(TIMEOUT);
`endif
            end else begin
               // Disabled slot: consume exactly one cycle, no start pulse
               slot_done_s = 1'b1;
            end
         end
         ST_INIT_WAIT, ST_SCAN_WAIT: begin
            if (ch_cmplt[idx_r] || wd_expire_s) begin
               slot_done_s = 1'b1;
            end else begin
`ifdef QSFP_SCAN_SEQ_TIMEOUT_EN
               next_cnt_s = cnt_r - 32'd1;
`endif
            end
         end
         ST_DELAY: begin
            if (cnt_r == 32'd0) begin
               next_state_s = ST_SCAN_ISSUE;
               next_idx_s   = '0;
            end else begin
               next_cnt_s = cnt_r - 32'd1;
            end
         end
         default: begin
            next_state_s = ST_RST;
            next_idx_s   = '0;
            next_cnt_s   = 32'(RST_DLY);
         end
      endcase

      // Advance to the next channel slot or finish the pass
      if (slot_done_s) begin
         if (idx_r == LAST_IDX) begin
            next_idx_s = '0;
            if (init_phase_s) begin
               next_state_s = ST_SCAN_ISSUE;
            end else begin
               next_state_s = ST_DELAY;
               next_cnt_s   = 32'(SCAN_PERIOD);
            end
         end else begin
            next_idx_s   = idx_r + IDX_W'(1);
            next_state_s = init_phase_s ? ST_INIT_ISSUE : ST_SCAN_ISSUE;
         end
      end else begin
         next_idx_s = next_idx_s;
      end
   end

   // Start pulses decoded from the ISSUE states
   always_comb begin
      ch_start = '0;
      ch_init  = '0;
      if ((state_r inside {ST_INIT_ISSUE, ST_SCAN_ISSUE}) && ch_enable[idx_r]) begin
         ch_start[idx_r] = 1'b1;
         ch_init[idx_r]  = (state_r == ST_INIT_ISSUE);
      end else begin
         ch_start = '0;
      end
   end

   // I2C bus mux: only the granted slot reaches the controller
   always_comb begin
      IO_CONTROL_PULSE = 1'b0;
      IO_CONTROL_RW    = 1'b0;
      IO_CONTROL_ID    = 8'h00;
      IO_ADDR_ADDR     = 8'h00;
      IO_WDATA_WDATA   = 8'h00;
      eng_cmplt        = '0;
      if (granted_s) begin
         IO_CONTROL_PULSE  = eng_pulse[slot_s];
         IO_CONTROL_RW     = eng_rw[slot_s];
         IO_CONTROL_ID     = eng_id[{slot_s, 3'b000} +: 8];
         IO_ADDR_ADDR      = eng_addr[{slot_s, 3'b000} +: 8];
         IO_WDATA_WDATA    = eng_wdata[{slot_s, 3'b000} +: 8];
         eng_cmplt[slot_s] = IO_CONTROL_CMPLT;
      end else begin
         eng_cmplt = '0;
      end
   end

   assign pwr_start = (state_r == ST_PWR_ISSUE);
   assign busy      = !(state_r inside {ST_RST, ST_DELAY});
   assign dbg_state = {5'b00000, state_r};
   assign eng_rdata = IO_RDATA_RDATA;

endmodule

// File: tb/tb_qsfp_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_qsfp_scan_sequencer
//
// Directed bench for qsfp_scan_sequencer. u_dut (N_CH=4, RST_DLY=10,
// SCAN_PERIOD=20, TIMEOUT=8) covers hold-off, sequencing with a channel
// mask, the bus mux, mid-operation reset and the watchdog (or its absence).
// u_edge (RST_DLY=1, SCAN_PERIOD=0, all channels disabled) covers the
// skip-only scan loop. Inputs change and outputs are checked on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_qsfp_scan_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ch_enable;
   logic        pwr_cmplt;
   logic [3:0]  ch_cmplt;
   logic [4:0]  eng_pulse, eng_rw;
   logic [39:0] eng_id, eng_addr, eng_wdata;
   logic [7:0]  io_rdata;
   logic        io_cmplt;

   logic        pwr_start, busy, io_pulse, io_rw;
   logic [3:0]  ch_start, ch_init;
   logic [7:0]  io_id, io_addr, io_wdata, eng_rdata, dbg_state;
   logic [4:0]  eng_cmplt, timeout_err;

   logic        e_rst, e_pwr_cmplt;
   logic        e_pwr_start, e_busy, e_io_pulse, e_io_rw;
   logic [3:0]  e_ch_start, e_ch_init;
   logic [7:0]  e_io_id, e_io_addr, e_io_wdata, e_eng_rdata, e_dbg_state;
   logic [4:0]  e_eng_cmplt, e_timeout_err;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   qsfp_scan_sequencer #(.N_CH(4), .RST_DLY(10), .SCAN_PERIOD(20), .TIMEOUT(8)) u_dut (
      .clk(clk), .rst(rst), .ch_enable(ch_enable),
      .pwr_start(pwr_start), .pwr_cmplt(pwr_cmplt),
      .ch_start(ch_start), .ch_init(ch_init), .ch_cmplt(ch_cmplt),
      .eng_pulse(eng_pulse), .eng_rw(eng_rw), .eng_id(eng_id),
      .eng_addr(eng_addr), .eng_wdata(eng_wdata),
      .IO_CONTROL_PULSE(io_pulse), .IO_CONTROL_RW(io_rw), .IO_CONTROL_ID(io_id),
      .IO_ADDR_ADDR(io_addr), .IO_WDATA_WDATA(io_wdata), .IO_RDATA_RDATA(io_rdata),
      .IO_CONTROL_CMPLT(io_cmplt), .eng_rdata(eng_rdata), .eng_cmplt(eng_cmplt),
      .timeout_err(timeout_err), .busy(busy), .dbg_state(dbg_state)
   );

   qsfp_scan_sequencer #(.N_CH(4), .RST_DLY(1), .SCAN_PERIOD(0), .TIMEOUT(8)) u_edge (
      .clk(clk), .rst(e_rst), .ch_enable(4'b0000),
      .pwr_start(e_pwr_start), .pwr_cmplt(e_pwr_cmplt),
      .ch_start(e_ch_start), .ch_init(e_ch_init), .ch_cmplt(4'b0000),
      .eng_pulse(5'b00000), .eng_rw(5'b00000), .eng_id(40'h0),
      .eng_addr(40'h0), .eng_wdata(40'h0),
      .IO_CONTROL_PULSE(e_io_pulse), .IO_CONTROL_RW(e_io_rw), .IO_CONTROL_ID(e_io_id),
      .IO_ADDR_ADDR(e_io_addr), .IO_WDATA_WDATA(e_io_wdata), .IO_RDATA_RDATA(8'h00),
      .IO_CONTROL_CMPLT(1'b0), .eng_rdata(e_eng_rdata), .eng_cmplt(e_eng_cmplt),
      .timeout_err(e_timeout_err), .busy(e_busy), .dbg_state(e_dbg_state)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // 10 cycles still in RST after release, pwr_start on the 11th
   task automatic holdoff();
      repeat (10) tick();
      chk("holdoff_early_pwr_start", 64'(pwr_start), 64'd0);
      chk("holdoff_early_state", 64'(dbg_state), 64'h00);
      tick();
      chk("holdoff_pwr_start", 64'(pwr_start), 64'd1);
      chk("holdoff_state", 64'(dbg_state), 64'h01);
   endtask

   // Serve one enabled channel: issue, wait, complete 5 cycles after start
   task automatic serve(input int ch, input bit init);
      logic [3:0] bit_v;
      bit_v = 4'b0001 << ch;
      chk($sformatf("issue_ch_start_%0d", ch), 64'(ch_start), 64'(bit_v));
      chk($sformatf("issue_ch_init_%0d", ch), 64'(ch_init), init ? 64'(bit_v) : 64'd0);
      chk($sformatf("issue_state_%0d", ch), 64'(dbg_state), init ? 64'h03 : 64'h05);
      ch_cmplt = bit_v;            // same-cycle completion must be ignored
      tick();
      ch_cmplt = 4'b0000;
      chk($sformatf("wait_state_%0d", ch), 64'(dbg_state), init ? 64'h04 : 64'h06);
      chk($sformatf("wait_no_start_%0d", ch), 64'(ch_start), 64'd0);
      repeat (4) tick();
      chk($sformatf("wait_hold_%0d", ch), 64'(dbg_state), init ? 64'h04 : 64'h06);
      ch_cmplt = bit_v;
      tick();
      ch_cmplt = 4'b0000;
   endtask

   initial begin
      rst = 1'b1; e_rst = 1'b1;
      ch_enable = 4'b1011; pwr_cmplt = 1'b0; ch_cmplt = 4'b0000; e_pwr_cmplt = 1'b0;
      eng_pulse = 5'b00000; eng_rw = 5'b00000;
      eng_id    = {8'h44, 8'h33, 8'hA0, 8'h11, 8'h50};
      eng_addr  = {8'h04, 8'h03, 8'h16, 8'h01, 8'h00};
      eng_wdata = {8'h0D, 8'h0C, 8'h3C, 8'h0A, 8'h09};
      io_rdata = 8'h00; io_cmplt = 1'b0;
      @(negedge clk);
      tick(); tick();

      // Reset state
      chk("rst_state", 64'(dbg_state), 64'h00);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pwr_start", 64'(pwr_start), 64'd0);
      chk("rst_ch_start", 64'(ch_start), 64'd0);
      chk("rst_io_id", 64'(io_id), 64'd0);
      chk("rst_timeout_err", 64'(timeout_err), 64'd0);
      rst = 1'b0;
      holdoff();

      // Power phase: pwr_cmplt 3 cycles after pwr_start
      tick();
      chk("pwr_wait_state", 64'(dbg_state), 64'h02);
      chk("pwr_wait_busy", 64'(busy), 64'd1);
      chk("pwr_grant_id", 64'(io_id), 64'h50);
      tick(); tick();
      chk("pwr_wait_hold", 64'(dbg_state), 64'h02);
      pwr_cmplt = 1'b1;
      tick();
      pwr_cmplt = 1'b0;

      // INIT pass over mask 1011
      serve(0, 1'b1);
      serve(1, 1'b1);
      chk("init_skip2_state", 64'(dbg_state), 64'h03);
      chk("init_skip2_start", 64'(ch_start), 64'd0);
      tick();
      serve(3, 1'b1);

      // SCAN pass
      serve(0, 1'b0);
      serve(1, 1'b0);
      chk("scan_skip2_state", 64'(dbg_state), 64'h05);
      chk("scan_skip2_start", 64'(ch_start), 64'd0);
      tick();
      serve(3, 1'b0);

      // DELAY: SCAN_PERIOD+1 = 21 cycles, bus idle
      chk("delay_state", 64'(dbg_state), 64'h07);
      chk("delay_busy", 64'(busy), 64'd0);
      chk("delay_io_id", 64'(io_id), 64'd0);
      io_cmplt = 1'b1;
      #1;
      chk("delay_eng_cmplt", 64'(eng_cmplt), 64'd0);
      io_cmplt = 1'b0;
      repeat (20) tick();
      chk("delay_last", 64'(dbg_state), 64'h07);
      tick();
      chk("rescan_state", 64'(dbg_state), 64'h05);
      chk("rescan_busy", 64'(busy), 64'd1);

      // Second SCAN pass, bus mux while ch1 is granted
      serve(0, 1'b0);
      chk("scan1_start", 64'(ch_start), 64'b0010);
      tick();
      eng_pulse = 5'b01100; eng_rw = 5'b00100; io_cmplt = 1'b1; io_rdata = 8'h5A;
      #1;
      chk("mux_id", 64'(io_id), 64'hA0);
      chk("mux_addr", 64'(io_addr), 64'h16);
      chk("mux_wdata", 64'(io_wdata), 64'h3C);
      chk("mux_rw", 64'(io_rw), 64'd1);
      chk("mux_pulse", 64'(io_pulse), 64'd1);
      chk("mux_eng_cmplt", 64'(eng_cmplt), 64'b00100);
      chk("mux_rdata", 64'(eng_rdata), 64'h5A);

      // Mid-operation reset in SCAN_WAIT ch1
      rst = 1'b1;
      tick();
      chk("midrst_state", 64'(dbg_state), 64'h00);
      chk("midrst_ch_start", 64'(ch_start), 64'd0);
      chk("midrst_pwr_start", 64'(pwr_start), 64'd0);
      chk("midrst_io_pulse", 64'(io_pulse), 64'd0);
      chk("midrst_io_id", 64'(io_id), 64'd0);
      chk("midrst_eng_cmplt", 64'(eng_cmplt), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_timeout_err", 64'(timeout_err), 64'd0);
      rst = 1'b0; eng_pulse = 5'b00000; eng_rw = 5'b00000; io_cmplt = 1'b0;
      holdoff();

      // Watchdog: all channels enabled, ch2 never completes
      ch_enable = 4'b1111;
      tick();
      pwr_cmplt = 1'b1;
      tick();
      pwr_cmplt = 1'b0;
      serve(0, 1'b1);
      serve(1, 1'b1);
      chk("wd_ch2_start", 64'(ch_start), 64'b0100);
      tick();
`ifdef QSFP_SCAN_SEQ_TIMEOUT_EN
      repeat (7) tick();
      chk("wd_pre_state", 64'(dbg_state), 64'h04);
      chk("wd_pre_err", 64'(timeout_err), 64'd0);
      tick();
      chk("wd_err", 64'(timeout_err), 64'b01000);
      chk("wd_adv_state", 64'(dbg_state), 64'h03);
      chk("wd_adv_start", 64'(ch_start), 64'b1000);
`else
      repeat (20) tick();
      chk("nowd_state", 64'(dbg_state), 64'h04);
      chk("nowd_err", 64'(timeout_err), 64'd0);
      chk("nowd_start", 64'(ch_start), 64'd0);
`endif

      // Edge instance: no channels, SCAN_PERIOD = 0
      e_rst = 1'b0;
      tick(); tick();
      chk("edge_pwr_issue", 64'(e_dbg_state), 64'h01);
      tick();
      e_pwr_cmplt = 1'b1;
      tick();
      e_pwr_cmplt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("edge_init_state_%0d", i), 64'(e_dbg_state), 64'h03);
         chk($sformatf("edge_init_start_%0d", i), 64'(e_ch_start), 64'd0);
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("edge_loop_state_%0d", i), 64'(e_dbg_state), (i % 5 == 4) ? 64'h07 : 64'h05);
         chk($sformatf("edge_loop_busy_%0d", i), 64'(e_busy), (i % 5 == 4) ? 64'd0 : 64'd1);
         chk($sformatf("edge_loop_start_%0d", i), 64'(e_ch_start), 64'd0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/qsfp_scan_sequencer.md
QSFP_SCAN_SEQUENCER -- requirements
Module: qsfp_scan_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of QSFP sideband channels, range 1..8.
REQ-002 SHALL have parameter RST_DLY, default 50000000: post-reset hold-off in clk cycles, minimum 1.
REQ-003 SHALL have parameter SCAN_PERIOD, default 50000000: idle cycles between scan passes; 0 is legal.
REQ-004 SHALL have parameter TIMEOUT, default 1000000: per-operation watchdog limit in cycles, minimum 1.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk in 1, the single clock; rst in 1, synchronous active-high reset.
REQ-006 SHALL have ch_enable in N_CH: per-channel participation mask, sampled when each channel slot is evaluated.
REQ-007 SHALL have pwr_start out 1 and pwr_cmplt in 1: power-engine start pulse and completion.
REQ-008 SHALL have ch_start out N_CH, ch_init out N_CH and ch_cmplt in N_CH: per-channel start pulse, init qualifier and completion.
REQ-009 SHALL have an engine-side bus: eng_pulse in N_CH+1, eng_rw in N_CH+1, and eng_id, eng_addr, eng_wdata in 8*(N_CH+1) each. Slot 0 is power; slot k+1 is channel k.
REQ-010 SHALL have an I2C-side bus: IO_CONTROL_PULSE out 1, IO_CONTROL_RW out 1, IO_CONTROL_ID out 8, IO_ADDR_ADDR out 8, IO_WDATA_WDATA out 8, IO_RDATA_RDATA in 8, IO_CONTROL_CMPLT in 1.
REQ-011 SHALL have eng_rdata out 8 and eng_cmplt out N_CH+1: read data and completion returned to the engines.
REQ-012 SHALL have timeout_err out N_CH+1 (sticky per slot), busy out 1 and dbg_state out 8.

Function
REQ-013 SHALL have states RST, PWR_ISSUE, PWR_WAIT, INIT_ISSUE, INIT_WAIT, SCAN_ISSUE, SCAN_WAIT, DELAY, encoded on dbg_state as 0x00..0x07.
REQ-014 SHALL hold in RST while the hold-off counter is nonzero; rst loads the counter with RST_DLY, and RST exits to PWR_ISSUE on the cycle the counter reaches 0.
REQ-015 SHALL go PWR_ISSUE -> PWR_WAIT unconditionally, and PWR_WAIT -> INIT phase on pwr_cmplt.
REQ-016 SHALL step the INIT phase and the SCAN phase through channel index idx = 0..N_CH-1 in ascending order.
REQ-017 SHALL skip a channel whose ch_enable bit is 0, with one cycle per skipped slot and no start pulse.
REQ-018 SHALL, in each ISSUE state, drive a 1-cycle start pulse: ch_start[idx]=1, plus ch_init[idx]=1 in INIT_ISSUE only.
REQ-019 SHALL leave a WAIT state on ch_cmplt[idx]; after the last index, INIT -> SCAN at idx 0, and SCAN -> DELAY.
REQ-020 SHALL load a counter with SCAN_PERIOD on entry to DELAY and go DELAY -> SCAN_ISSUE at idx 0 when it reaches 0; SCAN_PERIOD=0 gives one cycle in DELAY.
REQ-021 SHALL, with all ch_enable bits 0, pass through the INIT and SCAN phases in N_CH cycles each, then enter DELAY.
REQ-022 SHALL grant the I2C bus only to the active slot: power in PWR_WAIT, channel idx in INIT_WAIT or SCAN_WAIT. Otherwise all I2C-side outputs are 0.
REQ-023 SHALL make the I2C-side outputs a combinational mux of the granted slot's engine bus; ungranted eng_pulse is ignored.
REQ-024 SHALL route IO_CONTROL_CMPLT to the granted eng_cmplt bit only; the other eng_cmplt bits are 0; eng_rdata = IO_RDATA_RDATA.
REQ-025 SHALL assert busy in every state except DELAY and RST.
REQ-026 SHALL ignore a ch_cmplt or pwr_cmplt that arrives in the same cycle as its ISSUE pulse; it is only sampled in WAIT.

Reset
REQ-027 SHALL, on rst, set state=RST, idx=0 and timeout_err=0, and drive to 0 pwr_start, ch_start, ch_init, busy and all I2C-side outputs.
REQ-028 SHALL, on rst asserted mid-operation, abort on the next edge with no further start pulses, and re-run the full RST_DLY hold-off.

Configuration
REQ-029 SHALL, with macro QSFP_SCAN_SEQ_TIMEOUT_EN defined, run a watchdog in each WAIT state: loaded with TIMEOUT on entry, decremented each cycle.
REQ-030 SHALL, on watchdog expiry, set timeout_err[slot] (cleared only by rst) and advance as if completion had occurred.
REQ-031 SHALL, without QSFP_SCAN_SEQ_TIMEOUT_EN, wait indefinitely in WAIT states; timeout_err is then tied to 0 and no watchdog logic exists.

Verification
REQ-032 SHALL cover hold-off: N_CH=4, RST_DLY=10, pwr_cmplt 3 cycles after pwr_start -> pwr_start seen exactly 11 cycles after rst deasserts; then ch_start[0] with ch_init[0]=1.
REQ-033 SHALL cover sequencing: ch_enable=4'b1011, engines complete after 5 cycles -> INIT pulses on ch 0,1,3 only, then SCAN pulses on 0,1,3, then DELAY for SCAN_PERIOD=20 cycles, then repeat.
REQ-034 SHALL cover the bus mux: channel 1 drives id 0xA0 and addr 0x16 while granted, and channel 2 pulses simultaneously -> IO_CONTROL_ID=0xA0; IO_CONTROL_CMPLT appears only on eng_cmplt[2] (slot of ch1).
REQ-035 SHALL cover the watchdog: TIMEOUT_EN defined, TIMEOUT=8, ch 2 never completes -> timeout_err=5'b01000 after 8 WAIT cycles, and the sequencer advances to ch 3.
REQ-036 SHALL cover mid-operation reset: rst pulsed in SCAN_WAIT ch 1 -> next cycle dbg_state=0x00, all start and I2C outputs 0, timeout_err cleared.
REQ-037 SHALL cover the edge cases: ch_enable=0 with SCAN_PERIOD=0 -> no ch_start ever, state cycles SCAN-skip -> DELAY -> SCAN continuously, busy toggles accordingly.
